// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Purpose : shared timing constants, coordinate/colour types and the
//           colour-bar table for the VGA timing generator.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef logic [9:0]  coord_t;
    typedef logic [23:0] rgb_t;

    // Left-to-right bar order: white, yellow, cyan, green, magenta, red, blue, black.
    localparam rgb_t BAR_RGB [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic rgb_t bar_rgb(input logic [2:0] idx);
        return BAR_RGB[idx];
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Purpose : video timing bundle from the timing generator to the renderer.
// Signals : hsync, vsync, de, x, y, line_start, frame_start,
//           pattern_rgb (only when VGA_TEST_PATTERN_EN is defined).
// Modports: master (generator drives), slave (renderer samples).
// -----------------------------------------------------------------------------
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic   hsync;
    logic   vsync;
    logic   de;
    coord_t x;
    coord_t y;
    logic   line_start;
    logic   frame_start;
`ifdef VGA_TEST_PATTERN_EN
    rgb_t   pattern_rgb;
`endif

    modport master (
        output hsync, vsync, de, x, y, line_start, frame_start
`ifdef VGA_TEST_PATTERN_EN
        , pattern_rgb
`endif
    );

    modport slave (
        input hsync, vsync, de, x, y, line_start, frame_start
`ifdef VGA_TEST_PATTERN_EN
        , pattern_rgb
`endif
    );
endinterface

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// Purpose : one video axis. Counts 0..TOTAL-1 when enabled and decodes the
//           active region and the sync window from the current count.
// Ports   : clk_i    clock
//           srst_i   synchronous reset, active high (count -> 0)
//           en_i     advance the count this cycle
//           cnt_o    current count
//           first_o  count == 0
//           active_o count <  ACTIVE
//           sync_o   SYNC_START <= count < SYNC_END
// -----------------------------------------------------------------------------
module vga_axis_counter #(
    parameter  int TOTAL      = 800,
    parameter  int ACTIVE     = 640,
    parameter  int SYNC_START = 656,
    parameter  int SYNC_END   = 752,
    localparam int W          = $clog2(TOTAL)
) (
    input  logic         clk_i,
    input  logic         srst_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         first_o,
    output logic         active_o,
    output logic         sync_o
);
    localparam logic [W-1:0] LAST = W'(TOTAL - 1);
    // One extra bit so a window edge equal to TOTAL (e.g. zero back porch,
    // TOTAL = 1024) still fits.
    localparam logic [W:0] ACT_C = (W+1)'(ACTIVE);
    localparam logic [W:0] SS_C  = (W+1)'(SYNC_START);
    localparam logic [W:0] SE_C  = (W+1)'(SYNC_END);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0]   cnt_ext;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_ext  = {1'b0, cnt_q};
    assign cnt_o    = cnt_q;
    assign first_o  = (cnt_q == '0);
    assign active_o = (cnt_ext < ACT_C);
    assign sync_o   = (cnt_ext >= SS_C) && (cnt_ext < SE_C);

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Purpose : video timing generator in the pixel-clock domain (default
//           640x480@60, 800x525 total). All outputs are registered and
//           decode the counter value of the previous cycle.
// Ports   : clock_i       pixel clock from the PLL
//           reset_i       synchronous reset, active high
//           pll_locked_i  PLL lock; low behaves as an extra synchronous reset
//           vid           vga_timing_gen_if.master: hsync, vsync, de, x, y,
//                         line_start, frame_start [, pattern_rgb]
// Config  : VGA_TEST_PATTERN_EN - when defined, adds the registered 8-bar
//           colour test pattern on vid.pattern_rgb.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              pll_locked_i,
    vga_timing_gen_if.master  vid
);
    typedef vga_pkg::coord_t coord_t;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    // Lock loss is treated exactly like reset: the frame is aborted.
    logic srst;
    assign srst = reset_i | ~pll_locked_i;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_first, h_active, h_sync, h_last;
    logic          v_first, v_active, v_sync;

    assign h_last = (h_cnt == HW'(H_TOTAL - 1));

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
    ) u_h_axis (
        .clk_i    (clock_i),
        .srst_i   (srst),
        .en_i     (1'b1),
        .cnt_o    (h_cnt),
        .first_o  (h_first),
        .active_o (h_active),
        .sync_o   (h_sync)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
    ) u_v_axis (
        .clk_i    (clock_i),
        .srst_i   (srst),
        .en_i     (h_last),
        .cnt_o    (v_cnt),
        .first_o  (v_first),
        .active_o (v_active),
        .sync_o   (v_sync)
    );

    logic   hsync_d, hsync_q;
    logic   vsync_d, vsync_q;
    logic   de_d, de_q;
    coord_t x_d, x_q;
    coord_t y_d, y_q;
    logic   line_start_d, line_start_q;
    logic   frame_start_d, frame_start_q;

    always_comb begin
        hsync_d       = ~SYNC_POL;
        vsync_d       = ~SYNC_POL;
        de_d          = h_active & v_active;
        x_d           = '0;
        y_d           = '0;
        line_start_d  = h_first;
        frame_start_d = h_first & v_first;
        if (h_sync) hsync_d = SYNC_POL;
        if (v_sync) vsync_d = SYNC_POL;
        // Coordinates are parked at 0 outside the visible area.
        if (de_d) begin
            x_d = coord_t'(h_cnt);
            y_d = coord_t'(v_cnt);
        end
    end

    always_ff @(posedge clock_i) begin
        if (srst) begin
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.de          = de_q;
    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0]    bar_idx;
    vga_pkg::rgb_t pattern_d, pattern_q;

    // Bar index by threshold compare instead of a divider.
    always_comb begin
        bar_idx = 3'd0;
        for (int b = 1; b < 8; b++) begin
            if (32'(h_cnt) >= 32'(b * BAR_W)) bar_idx = 3'(b);
        end
        pattern_d = de_d ? vga_pkg::bar_rgb(bar_idx) : '0;
    end

    always_ff @(posedge clock_i) begin
        if (srst) begin
            pattern_q <= '0;
        end else begin
            pattern_q <= pattern_d;
        end
    end

    assign vid.pattern_rgb = pattern_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
    // Full 800-pixel lines; a short frame keeps whole-frame checks cheap.
    localparam int VA    = 12;
    localparam int VFP   = 2;
    localparam int VS    = 2;
    localparam int VBP   = 4;
    localparam int VT    = VA + VFP + VS + VBP;
    localparam int HT    = 800;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        ls;
        logic        fs;
        logic [23:0] rgb;
    } vout_t;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic locked = 1'b1;

    always #5 clk = ~clk;

    vga_timing_gen_if vid ();

    vga_timing_gen #(
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VS),
        .V_BP     (VBP)
    ) dut (
        .clock_i      (clk),
        .reset_i      (reset),
        .pll_locked_i (locked),
        .vid          (vid)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    vout_t sb_q[$];
    vout_t exp_v, obs_v, m_e;
    vout_t rst_v = '{hs: 1'b1, vs: 1'b1, default: '0};
    int    m_h = 0;
    int    m_v = 0;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // Reference model: at each edge, predict the registered outputs from the
    // inputs and the model counters, then advance the counters.
    always @(posedge clk) begin
        m_e    = '0;
        m_e.hs = 1'b1;
        m_e.vs = 1'b1;
        if (reset || !locked) begin
            m_h = 0;
            m_v = 0;
        end else begin
            m_e.de = (m_h < 640) && (m_v < VA);
            if (m_e.de) begin
                m_e.x = 10'(m_h);
                m_e.y = 10'(m_v);
`ifdef VGA_TEST_PATTERN_EN
                m_e.rgb = bars[m_h / 80];
`endif
            end
            m_e.hs = !(m_h >= 656 && m_h < 752);
            m_e.vs = !(m_v >= VA + VFP && m_v < VA + VFP + VS);
            m_e.ls = (m_h == 0);
            m_e.fs = (m_h == 0) && (m_v == 0);
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
        sb_q.push_back(m_e);
    end

    function automatic vout_t sample();
        vout_t o;
        o.hs  = vid.hsync;
        o.vs  = vid.vsync;
        o.de  = vid.de;
        o.x   = vid.x;
        o.y   = vid.y;
        o.ls  = vid.line_start;
        o.fs  = vid.frame_start;
        o.rgb = '0;
`ifdef VGA_TEST_PATTERN_EN
        o.rgb = vid.pattern_rgb;
`endif
        return o;
    endfunction

    // Advance one cycle, sample the DUT mid-cycle and pop the prediction.
    task automatic step();
        @(negedge clk);
        obs_v = sample();
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_underflow: queue empty at %0t", $time);
            exp_v = '0;
        end else begin
            exp_v = sb_q.pop_front();
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        locked = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (obs_v !== rst_v) begin
                n_fail++;
                $display("FAIL reset_values: got %h required %h", obs_v, rst_v);
            end
        end
    endtask

    // Counters sit at 0 in the cycle the reset drops; the decoded outputs
    // (frame_start) appear after the following edge.
    task automatic test_release();
        int lat = -1;
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            n_tests++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL release_sb: got %h required %h", obs_v, exp_v);
            end
            if (obs_v.fs) begin
                lat = i;
                break;
            end
        end
        n_tests++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL release_latency: got %0d edges required 1", lat);
        end
        n_tests++;
        if (!(obs_v.de === 1'b1 && obs_v.x === 10'd0 && obs_v.y === 10'd0 && obs_v.ls === 1'b1)) begin
            n_fail++;
            $display("FAIL first_pixel: de=%b x=%0d y=%0d ls=%b required 1 0 0 1",
                     obs_v.de, obs_v.x, obs_v.y, obs_v.ls);
        end
    endtask

    // Entered with frame_start visible; runs to the next frame_start.
    task automatic test_frame();
        int last_ls = 0, lines = 1, line = 0, off = 0;
        int de_tot = 1, de_late = 0, de_l0 = 1;
        int hs_l0 = 0, hs_first = -1;
        int vs_low = 0, vs_line = -1, vs_off = -1, period = -1;
        for (int i = 1; i <= FRAME + 10; i++) begin
            step();
            n_tests++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL frame_sb: cycle %0d got %h required %h", i, obs_v, exp_v);
            end
            if (obs_v.fs) begin
                period = i;
                break;
            end
            if (obs_v.ls) begin
                n_tests++;
                if (i - last_ls != HT) begin
                    n_fail++;
                    $display("FAIL line_period: got %0d required %0d", i - last_ls, HT);
                end
                last_ls = i;
                line++;
                lines++;
            end
            off = i - last_ls;
            if (obs_v.de) begin
                de_tot++;
                if (line >= VA) de_late++;
                if (line == 0) de_l0++;
            end
            if (line == 0 && !obs_v.hs) begin
                hs_l0++;
                if (hs_first < 0) hs_first = off;
            end
            if (!obs_v.vs) begin
                vs_low++;
                if (vs_line < 0) begin
                    vs_line = line;
                    vs_off  = off;
                end
            end
        end
        n_tests++;
        if (period != FRAME) begin n_fail++; $display("FAIL frame_period: got %0d required %0d", period, FRAME); end
        n_tests++;
        if (lines != VT) begin n_fail++; $display("FAIL line_count: got %0d required %0d", lines, VT); end
        n_tests++;
        if (de_l0 != 640) begin n_fail++; $display("FAIL de_per_line: got %0d required 640", de_l0); end
        n_tests++;
        if (de_tot != 640 * VA) begin n_fail++; $display("FAIL de_per_frame: got %0d required %0d", de_tot, 640 * VA); end
        n_tests++;
        if (de_late != 0) begin n_fail++; $display("FAIL de_blank_lines: got %0d required 0", de_late); end
        n_tests++;
        if (hs_l0 != 96) begin n_fail++; $display("FAIL hsync_width: got %0d required 96", hs_l0); end
        n_tests++;
        if (hs_first != 656) begin n_fail++; $display("FAIL hsync_start: got %0d required 656", hs_first); end
        n_tests++;
        if (vs_low != VS * HT) begin n_fail++; $display("FAIL vsync_width: got %0d required %0d", vs_low, VS * HT); end
        n_tests++;
        if (vs_line != VA + VFP || vs_off != 0) begin
            n_fail++;
            $display("FAIL vsync_start: got line %0d off %0d required line %0d off 0", vs_line, vs_off, VA + VFP);
        end
    endtask

    // Entered at frame start; drops lock at line 5, x=300 for 5 cycles.
    task automatic test_lock_drop();
        int lat = -1;
        for (int i = 0; i < 5 * HT + 300; i++) begin
            step();
            n_tests++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL lock_run_sb: got %h required %h", obs_v, exp_v);
            end
        end
        n_tests++;
        if (obs_v.x !== 10'd300 || obs_v.y !== 10'd5) begin
            n_fail++;
            $display("FAIL lock_position: got x=%0d y=%0d required x=300 y=5", obs_v.x, obs_v.y);
        end
        locked = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if (obs_v !== rst_v) begin
                n_fail++;
                $display("FAIL lock_loss_values: got %h required %h", obs_v, rst_v);
            end
        end
        locked = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            n_tests++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL relock_sb: got %h required %h", obs_v, exp_v);
            end
            if (obs_v.fs) begin
                lat = i;
                break;
            end
        end
        n_tests++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL relock_latency: got %0d edges required 1", lat);
        end
    endtask

    task automatic test_reset_and_lock();
        int lat = -1;
        reset  = 1'b1;
        locked = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (obs_v !== rst_v) begin
                n_fail++;
                $display("FAIL both_low_values: got %h required %h", obs_v, rst_v);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_tests++;
            if (obs_v !== rst_v) begin
                n_fail++;
                $display("FAIL wait_lock_values: got %h required %h", obs_v, rst_v);
            end
        end
        locked = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            n_tests++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL lock_rise_sb: got %h required %h", obs_v, exp_v);
            end
            if (obs_v.fs) begin
                lat = i;
                break;
            end
        end
        n_tests++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL lock_rise_latency: got %0d edges required 1", lat);
        end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    // Entered at frame start (x=0 visible); walks one line.
    task automatic test_pattern();
        n_tests++;
        if (obs_v.rgb !== 24'hFFFFFF) begin
            n_fail++;
            $display("FAIL pattern_x0: got %h required FFFFFF", obs_v.rgb);
        end
        for (int off = 1; off < HT; off++) begin
            step();
            n_tests++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL pattern_sb: got %h required %h", obs_v, exp_v);
            end
            if (off == 80) begin
                n_tests++;
                if (obs_v.rgb !== 24'hFFFF00) begin n_fail++; $display("FAIL pattern_x80: got %h required FFFF00", obs_v.rgb); end
            end
            if (off == 160) begin
                n_tests++;
                if (obs_v.rgb !== 24'h00FFFF) begin n_fail++; $display("FAIL pattern_x160: got %h required 00FFFF", obs_v.rgb); end
            end
            if (off == 639) begin
                n_tests++;
                if (obs_v.rgb !== 24'h000000 || obs_v.de !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pattern_x639: got %h de=%b required 000000 de=1", obs_v.rgb, obs_v.de);
                end
            end
            if (off == 700) begin
                n_tests++;
                if (obs_v.rgb !== 24'h000000 || obs_v.de !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pattern_blank: got %h de=%b required 000000 de=0", obs_v.rgb, obs_v.de);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_release();
        test_frame();
        test_lock_drop();
        test_reset_and_lock();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
